// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec_unit
// Description : ALU execution unit with valid/ready handshakes on both sides.
//               Logic, add/sub, signed compare and branch compare complete in
//               one cycle. SLL/SRL shift one bit per cycle unless the macro
//               ALU_FAST_SHIFT_EN is defined, which selects a single-cycle
//               barrel shifter instead.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       aluctl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cond,
  output logic             illegal
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0011;
  localparam logic [3:0] OP_SRL = 4'b0100;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_BNE = 4'b1000;
  localparam logic [3:0] OP_XOR = 4'b1100;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             left_q, left_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cond_q, cond_d;
  logic             illegal_q, illegal_d;

  logic [SHW-1:0]   w_amt;
  logic [WIDTH-1:0] w_res;
  logic             w_cond;
  logic             w_ill;
  logic             w_iter;
  logic [WIDTH-1:0] w_step;

  assign w_amt  = op_b[SHW-1:0];
  assign w_step = left_q ? (work_q << 1) : (work_q >> 1);

`ifdef ALU_FAST_SHIFT_EN
  assign w_iter = 1'b0;
`else
  // Only nonzero shifts take the iterative path; a zero shift is a plain copy.
  assign w_iter = ((aluctl == OP_SLL) || (aluctl == OP_SRL)) && (w_amt != '0);
`endif

  // Single-cycle datapath evaluated on the request operands.
  always_comb begin
    w_res  = '0;
    w_cond = 1'b0;
    w_ill  = 1'b0;
    case (aluctl)
      OP_AND: w_res = op_a & op_b;
      OP_OR:  w_res = op_a | op_b;
      OP_XOR: w_res = op_a ^ op_b;
      OP_ADD: w_res = op_a + op_b;
      OP_SUB: begin
        w_res  = op_a - op_b;
        w_cond = (op_a == op_b);
      end
      OP_BNE: begin
        w_res  = op_a - op_b;
        w_cond = (op_a != op_b);
      end
      OP_SLT: w_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
`ifdef ALU_FAST_SHIFT_EN
      OP_SLL: w_res = op_a << w_amt;
      OP_SRL: w_res = op_a >> w_amt;
`else
      OP_SLL: w_res = op_a;
      OP_SRL: w_res = op_a;
`endif
      default: w_ill = 1'b1;
    endcase
  end

  // Next-state and handshake outputs of the IDLE/SHIFT/DONE controller.
  always_comb begin
    state_d   = state_q;
    work_d    = work_q;
    cnt_d     = cnt_q;
    left_d    = left_q;
    result_d  = result_q;
    cond_d    = cond_q;
    illegal_d = illegal_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (w_iter) begin
            work_d  = op_a;
            cnt_d   = w_amt;
            left_d  = (aluctl == OP_SLL);
            state_d = S_SHIFT;
          end else begin
            result_d  = w_res;
            cond_d    = w_cond;
            illegal_d = w_ill;
            state_d   = S_DONE;
          end
        end
      end
      S_SHIFT: begin
        work_d = w_step;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == 1) begin
          result_d  = w_step;
          cond_d    = 1'b0;
          illegal_d = 1'b0;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      work_q    <= '0;
      cnt_q     <= '0;
      left_q    <= 1'b0;
      result_q  <= '0;
      cond_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      work_q    <= work_d;
      cnt_q     <= cnt_d;
      left_q    <= left_d;
      result_q  <= result_d;
      cond_q    <= cond_d;
      illegal_q <= illegal_d;
    end
  end

  assign result  = result_q;
  assign cond    = cond_q;
  assign illegal = illegal_q;

endmodule
`default_nettype wire

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width in bits (power of two, 8..64).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the operation request is valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the unit accepts a request this cycle.
REQ-006 The block SHALL have port aluctl, input, 4 bits: operation code from the ALU control decoder.
REQ-007 The block SHALL have ports op_a and op_b, input, WIDTH bits each: the operands.
REQ-008 The block SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-010 The block SHALL have port result, output, WIDTH bits: the operation result.
REQ-011 The block SHALL have port cond, output, 1 bit: the branch-compare outcome.
REQ-012 The block SHALL have port illegal, output, 1 bit: the accepted aluctl was unsupported.

Function
REQ-013 The block SHALL decode aluctl as follows: 0000 AND; 0001 OR; 0010 ADD; 0110 SUB; 0111 SLT (signed, result 1 or 0); 1100 XOR; 0011 SLL; 0100 SRL (logical); 1000 BNE-compare (result a-b).
REQ-014 The block SHALL set cond=(op_a==op_b) for 0110, cond=(op_a!=op_b) for 1000, and cond=0 for every other code.
REQ-015 The block SHALL produce result=0, cond=0 and illegal=1 for any other aluctl code, with single-cycle latency.
REQ-016 The block SHALL discard add/sub carry out; arithmetic wraps modulo 2^WIDTH.
REQ-017 The block SHALL take the shift amount as op_b[log2(WIDTH)-1:0] and ignore the upper bits of op_b.
REQ-018 The block SHALL implement an FSM with states IDLE, SHIFT and DONE.
REQ-019 In IDLE, in_ready SHALL be 1; a transfer occurs on in_valid&&in_ready, and the operands and aluctl SHALL be registered.
REQ-020 On acceptance of a non-shift op, or of a shift with amount 0, the FSM SHALL go to DONE on the next edge, giving a latency of 1 cycle.
REQ-021 On acceptance of a shift with amount N>0, the FSM SHALL enter SHIFT, shift the working register by 1 bit per cycle and decrement a counter, and reach DONE after N cycles (latency N+1).
REQ-022 In SHIFT and DONE, in_ready SHALL be 0; in_valid SHALL be ignored.
REQ-023 In DONE, out_valid SHALL be 1; result, cond and illegal SHALL hold stable until out_ready=1, after which the FSM returns to IDLE on that edge.
REQ-024 The block SHALL NOT accept a new request in the cycle the result is consumed; back-to-back throughput is one op per 2 cycles minimum.
REQ-025 Outside DONE, out_valid SHALL be 0; result, cond and illegal SHALL retain their last values.

Reset
REQ-026 On rst=1, asynchronously, the FSM SHALL go to IDLE, and out_valid, result, cond, illegal and the shift counter SHALL be 0; in_ready SHALL be 1 after reset release.
REQ-027 Reset asserted in SHIFT or DONE SHALL abort the operation and discard its result.

Configuration
REQ-028 With macro ALU_FAST_SHIFT_EN defined, SLL and SRL SHALL be computed by a single-cycle barrel shifter (latency 1, state SHIFT unused); with it undefined, the iterative shifting of REQ-021 SHALL apply.

Verification
REQ-029 ADD: aluctl=0010, a=0xFFFFFFFF, b=0x00000002 -> out_valid 1 cycle after accept, result=0x00000001, cond=0.
REQ-030 SUB and BNE: aluctl=0110, a=b=0x1234 -> result=0, cond=1; aluctl=1000, a=5, b=3 -> result=2, cond=1.
REQ-031 SLT signed: aluctl=0111, a=0xFFFFFFFF, b=0x00000001 -> result=1; with a and b swapped -> result=0.
REQ-032 SLL iterative: aluctl=0011, a=0x1, b=0x25 (shift 5) -> result=0x20 with out_valid 6 cycles after accept, and in_ready=0 throughout; with ALU_FAST_SHIFT_EN defined -> out_valid after 1 cycle.
REQ-033 Backpressure and illegal code: aluctl=1111 with out_ready=0 for 4 cycles -> out_valid held, result=0, illegal=1 stable; release after out_ready=1 -> in_ready=1 the next cycle.
REQ-034 Reset mid-shift: SRL a=0x80000000, b=31; rst pulsed 3 cycles after accept -> out_valid=0, result=0, in_ready=1, with no late result.
